// File: rtl/instruction_fetch_controller_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_controller_pkg
// Shared types and constants for the stage-1 instruction fetch controller.
//   word          : 32-bit machine word
//   fetch_entry_t : {pc, instruction} pair carried through the skid FIFO
//   INSTR_BYTES   : PC increment between sequential instructions
//   word_align()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package instruction_fetch_controller_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word pc;
    word instruction;
  } fetch_entry_t;

  localparam word INSTR_BYTES = 32'd4;

  // Instructions are word aligned, so the low address bits carry no meaning.
  function automatic word word_align(input word addr);
    return addr & ~(INSTR_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_controller_if
// Bundles the fetch controller's control, memory and downstream signals.
//   fetch_enable    : allow new reads
//   redirect_valid  : one-cycle redirect request
//   redirect_pc     : redirect target (low two bits ignored)
//   mem_read        : read strobe to instruction memory
//   mem_addr        : byte address to instruction memory
//   mem_instruction : memory data, valid the cycle after mem_read
//   out_ready       : downstream accepts this cycle
//   out_valid       : out_pc/out_instruction hold a valid fetch
//   out_pc          : PC of the presented instruction
//   out_instruction : presented instruction
// Modports: master = the controller, slave = memory/pipeline side.
// ---------------------------------------------------------------------------
interface instruction_fetch_controller_if;
  import instruction_fetch_controller_pkg::*;

  logic fetch_enable;
  logic redirect_valid;
  word  redirect_pc;
  logic mem_read;
  word  mem_addr;
  word  mem_instruction;
  logic out_ready;
  logic out_valid;
  word  out_pc;
  word  out_instruction;

  modport master (
    input  fetch_enable,
    input  redirect_valid,
    input  redirect_pc,
    input  mem_instruction,
    input  out_ready,
    output mem_read,
    output mem_addr,
    output out_valid,
    output out_pc,
    output out_instruction
  );

  modport slave (
    output fetch_enable,
    output redirect_valid,
    output redirect_pc,
    output mem_instruction,
    output out_ready,
    input  mem_read,
    input  mem_addr,
    input  out_valid,
    input  out_pc,
    input  out_instruction
  );

endinterface

// File: rtl/instruction_fetch_controller_skid_fifo.sv
// ---------------------------------------------------------------------------
// fetch_skid_fifo
// Small FIFO of fetch entries that absorbs responses while downstream stalls.
//   clock, reset_n : clock and asynchronous active-low reset
//   push, entry_in : write entry_in at the tail
//   pop            : drop the head (caller only pops when non-empty)
//   flush          : empty the FIFO; overrides push and pop
//   count          : number of valid entries
//   head           : oldest entry (meaningful only when count != 0)
// The pointer wrap below is written for any DEPTH, but the controller is
// only ever built with DEPTH = 2.
// ---------------------------------------------------------------------------
module fetch_skid_fifo
  import instruction_fetch_controller_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  fetch_entry_t       entry_in,
  input  logic               pop,
  input  logic               flush,
  output logic [COUNT_W-1:0] count,
  output fetch_entry_t       head
);

  fetch_entry_t storage_reg [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [DEPTH-1:0]   wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // One write enable per slot; a flush discards any same-cycle push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push & ~flush & (wr_ptr_reg == PTR_W'(gi));
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_next = count_reg + COUNT_W'(1);
        2'b01:   count_next = count_reg - COUNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) storage_reg[i] <= entry_in;
    end
  end

  assign count = count_reg;
  assign head  = storage_reg[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch_controller.sv
// ---------------------------------------------------------------------------
// instruction_fetch_controller
// Stage-1 sequencer for the synchronous instruction memory. Owns the PC,
// issues at most one read per cycle, tracks the single in-flight read and
// presents responses in program order, buffering up to two in a skid FIFO.
// A redirect squashes the in-flight response and all buffered entries.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : instruction_fetch_controller_if.master (control, memory and
//             downstream handshake signals)
// Parameters: RESET_PC (word aligned), FIFO_DEPTH (only 2 is supported).
// ---------------------------------------------------------------------------
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter word RESET_PC   = 32'h0000_0000,
  parameter int  FIFO_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  instruction_fetch_controller_if.master bus
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  word  pc_reg, pc_next;
  word  inflight_pc_reg, inflight_pc_next;
  logic inflight_reg, inflight_next;

  logic [COUNT_W-1:0] fifo_count;
  fetch_entry_t       fifo_head;
  fetch_entry_t       response;
  fetch_entry_t       out_entry;

  word  redirect_addr;
  word  issue_addr;
  logic space;
  logic issue;
  logic fifo_empty;
  logic present_valid;
  logic accept;
  logic push;
  logic pop;

  assign redirect_addr = word_align(bus.redirect_pc);

  // Room check deliberately ignores a same-cycle dequeue so it never depends
  // on out_ready; this costs nothing at full throughput since a bypassed
  // response is not counted in the FIFO.
  assign space = (int'(fifo_count) + int'(inflight_reg)) <= 1;

  // A redirect flushes the FIFO, so it may always issue. Reset masks the
  // strobe combinationally so it drops without waiting for a clock edge.
  assign issue      = reset_n & bus.fetch_enable & (space | bus.redirect_valid);
  assign issue_addr = bus.redirect_valid ? redirect_addr : pc_reg;

  assign bus.mem_read = issue;
  assign bus.mem_addr = reset_n ? issue_addr : RESET_PC;

  always_comb begin
    pc_next          = pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = issue;
    if (issue) begin
      inflight_pc_next = issue_addr;
      pc_next          = issue_addr + INSTR_BYTES;
    end else if (bus.redirect_valid) begin
      // Redirect while disabled: remember the target for the next issue.
      pc_next = redirect_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg          <= RESET_PC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      inflight_pc_reg <= inflight_pc_next;
      inflight_reg    <= inflight_next;
    end
  end

  // The memory response only means something in the cycle after the read.
  assign response = '{pc: inflight_pc_reg, instruction: bus.mem_instruction};

  assign fifo_empty    = (fifo_count == '0);
  assign present_valid = ~bus.redirect_valid & (~fifo_empty | inflight_reg);
  assign accept        = present_valid & bus.out_ready;

  // A bypassed response that is taken immediately never touches the FIFO.
  assign push = inflight_reg & ~bus.redirect_valid & ~(fifo_empty & accept);
  assign pop  = accept & ~fifo_empty;

  always_comb begin
    out_entry = '0;
    if (!bus.redirect_valid) begin
      if (!fifo_empty) begin
        out_entry = fifo_head;
      end else if (inflight_reg) begin
        out_entry = response;
      end
    end
  end

  assign bus.out_valid       = present_valid;
  assign bus.out_pc          = out_entry.pc;
  assign bus.out_instruction = out_entry.instruction;

  fetch_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_skid_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .entry_in (response),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule
